// File: rtl/pq_expiry_dispatcher.sv
// Expiry dispatcher for the array priority queue.
// Keeps the system time base, compares it with the deadline of the queue head,
// and pops the head once it is due (or when flushing). Each popped entry is
// offered downstream on a valid/ready event port.
module pq_expiry_dispatcher #(
    parameter int TIME_WIDTH     = 24,
    parameter int LATE_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      tick_en_i,
    output logic [TIME_WIDTH-1:0]     time_o,
    input  logic                      flush_i,
    input  logic                      q_empty_i,
    input  logic [TIME_WIDTH-1:0]     q_head_data_i,
    input  logic [TIME_WIDTH-1:0]     q_head_id_i,
    output logic                      q_pop_o,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [TIME_WIDTH-1:0]     evt_id_o,
    output logic [TIME_WIDTH-1:0]     evt_time_o,
    output logic                      evt_late_o,
    output logic [LATE_CNT_WIDTH-1:0] late_cnt_o
);

    typedef enum logic [1:0] {
        ST_CHECK  = 2'd0,
        ST_POP    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [TIME_WIDTH-1:0]     time_reg;
    logic [TIME_WIDTH-1:0]     evt_id_reg;
    logic [TIME_WIDTH-1:0]     evt_time_reg;
    logic                      evt_late_reg;
    logic [LATE_CNT_WIDTH-1:0] late_cnt_reg;
    logic                      accepted_reg;

    logic [TIME_WIDTH-1:0]     diff;
    logic                      late;
    logic                      expired;
    logic                      capture;
    logic                      pop;
    logic                      valid;

    // Modular distance from now to the head deadline; a set MSB means the
    // deadline lies in the past (deadlines are kept within half the range).
    assign diff    = q_head_data_i - time_reg;
    assign late    = diff[TIME_WIDTH-1];
    assign expired = (diff == '0) || late;

    // Next-state and output decode for the release sequence
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        pop        = 1'b0;
        valid      = 1'b0;
        case (state_reg)
            ST_CHECK: begin
                if (!q_empty_i && (expired || flush_i)) begin
                    capture    = 1'b1;
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                pop        = 1'b1;
                valid      = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Still offering the event unless it was taken during POP;
                // a handshake here also completes the delivery.
                valid = !accepted_reg;
                if (accepted_reg || evt_ready_i) begin
                    state_next = ST_CHECK;
                end else begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                valid = 1'b1;
                if (evt_ready_i) begin
                    state_next = ST_CHECK;
                end
            end
            default: state_next = ST_CHECK;
        endcase
    end

    // State register and the time base
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= ST_CHECK;
            time_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (tick_en_i) begin
                time_reg <= time_reg + TIME_WIDTH'(1);
            end
        end
    end

    // Event capture, delivery bookkeeping and the saturating late counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            evt_id_reg   <= '0;
            evt_time_reg <= '0;
            evt_late_reg <= 1'b0;
            late_cnt_reg <= '0;
            accepted_reg <= 1'b0;
        end else begin
            // Remembers whether the event was already taken in the POP cycle
            accepted_reg <= (state_reg == ST_POP) && evt_ready_i;
            if (capture) begin
                evt_id_reg   <= q_head_id_i;
                evt_time_reg <= q_head_data_i;
                evt_late_reg <= late;
                if (late && (late_cnt_reg != {LATE_CNT_WIDTH{1'b1}})) begin
                    late_cnt_reg <= late_cnt_reg + LATE_CNT_WIDTH'(1);
                end
            end
        end
    end

    assign time_o      = time_reg;
    assign q_pop_o     = pop;
    assign evt_valid_o = valid;
    assign evt_id_o    = evt_id_reg;
    assign evt_time_o  = evt_time_reg;
    assign evt_late_o  = evt_late_reg;
    assign late_cnt_o  = late_cnt_reg;

endmodule

// File: tb/tb_pq_expiry_dispatcher.sv
// Bench for pq_expiry_dispatcher: a sorted-queue model feeds the head port,
// expected events go to a scoreboard and are checked on each handshake.
// TIME_WIDTH is reduced to 13 so wrap-around is reachable in a short run.
module tb_pq_expiry_dispatcher;

    localparam int TW = 13;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          tick_en_i = 1'b0;
    logic [TW-1:0] time_o;
    logic          flush_i = 1'b0;
    logic          q_empty_i = 1'b1;
    logic [TW-1:0] q_head_data_i = '0;
    logic [TW-1:0] q_head_id_i = '0;
    logic          q_pop_o;
    logic          evt_valid_o;
    logic          evt_ready_i = 1'b0;
    logic [TW-1:0] evt_id_o;
    logic [TW-1:0] evt_time_o;
    logic          evt_late_o;
    logic [LW-1:0] late_cnt_o;

    always #5 clk = ~clk;

    pq_expiry_dispatcher #(.TIME_WIDTH(TW), .LATE_CNT_WIDTH(LW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tick_en_i(tick_en_i), .time_o(time_o),
        .flush_i(flush_i), .q_empty_i(q_empty_i), .q_head_data_i(q_head_data_i),
        .q_head_id_i(q_head_id_i), .q_pop_o(q_pop_o), .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i), .evt_id_o(evt_id_o), .evt_time_o(evt_time_o),
        .evt_late_o(evt_late_o), .late_cnt_o(late_cnt_o)
    );

    typedef struct packed {
        logic [TW-1:0] data;
        logic [TW-1:0] id;
    } ent_t;

    typedef struct packed {
        logic [TW-1:0] id;
        logic [TW-1:0] t;
        logic          late;
    } evt_t;

    typedef struct {
        int delta;
        bit flush;
        bit empty;
        bit exp_pop;
        bit exp_late;
    } vec_t;

    ent_t          mq[$];
    evt_t          exq[$];
    vec_t          vt[7];
    int            total = 0;
    int            bad = 0;
    int            pop_cnt = 0;
    int            cyc = 0;
    logic [TW-1:0] tb_time = '0;
    bit            rand_in = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_head();
        if (rand_in) begin
            q_empty_i     = 1'($urandom_range(0, 1));
            q_head_data_i = TW'($urandom);
            q_head_id_i   = TW'($urandom);
        end else if (mq.size() == 0) begin
            q_empty_i     = 1'b1;
            q_head_data_i = '0;
            q_head_id_i   = '0;
        end else begin
            q_empty_i     = 1'b0;
            q_head_data_i = mq[0].data;
            q_head_id_i   = mq[0].id;
        end
    endtask

    task automatic push(input logic [TW-1:0] data, input logic [TW-1:0] id);
        ent_t e;
        int   k = 0;
        e.data = data;
        e.id   = id;
        while (k < mq.size() && mq[k].data <= data) k++;
        mq.insert(k, e);
        drive_head();
    endtask

    task automatic expect_evt(input logic [TW-1:0] id, input logic [TW-1:0] t, input logic late);
        evt_t e;
        e.id   = id;
        e.t    = t;
        e.late = late;
        exq.push_back(e);
    endtask

    // One clock: score a handshake, advance the time model, apply pops to the
    // queue model, then present the new head.
    task automatic step();
        evt_t e;
        if (rst_ni && evt_valid_o && evt_ready_i) begin
            if (exq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_evt: got id %0h want none", evt_id_o);
            end else begin
                e = exq.pop_front();
                chk("evt_id", 32'(evt_id_o), 32'(e.id));
                chk("evt_time", 32'(evt_time_o), 32'(e.t));
                chk("evt_late", 32'(evt_late_o), 32'(e.late));
            end
        end
        if (!rst_ni) tb_time = '0;
        else if (tick_en_i) tb_time = tb_time + TW'(1);
        @(posedge clk);
        #1;
        cyc++;
        if (rst_ni && q_pop_o) begin
            pop_cnt++;
            if (mq.size() > 0) void'(mq.pop_front());
        end
        drive_head();
    endtask

    task automatic wait_pop(input string name, input int budget);
        bit seen = 1'b0;
        int p;
        for (int i = 0; i < budget && !seen; i++) begin
            p = pop_cnt;
            step();
            if (pop_cnt != p) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: got no pop want pop within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        mq.delete();
        exq.delete();
        drive_head();
        step();
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        int            p0;
        int            p;
        int            pc[$];
        logic [TW-1:0] d;

        //          delta  flush empty pop late
        vt[0] = '{0,     1'b0, 1'b0, 1'b1, 1'b0};  // due now: on time
        vt[1] = '{-1,    1'b0, 1'b0, 1'b1, 1'b1};  // one tick late
        vt[2] = '{1,     1'b0, 1'b0, 1'b0, 1'b0};  // one tick in the future
        vt[3] = '{1,     1'b1, 1'b0, 1'b1, 1'b0};  // flushed future entry
        vt[4] = '{-3,    1'b1, 1'b1, 1'b0, 1'b0};  // empty queue, flush ignored
        vt[5] = '{4096,  1'b0, 1'b0, 1'b1, 1'b1};  // half-range: counts as past
        vt[6] = '{4095,  1'b0, 1'b0, 1'b0, 1'b0};  // furthest future deadline

        // Reset with random inputs
        rand_in = 1'b1;
        repeat (3) begin
            tick_en_i   = 1'($urandom_range(0, 1));
            flush_i     = 1'($urandom_range(0, 1));
            evt_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        chk("rst_time", 32'(time_o), 0);
        chk("rst_pop", 32'(q_pop_o), 0);
        chk("rst_valid", 32'(evt_valid_o), 0);
        chk("rst_id", 32'(evt_id_o), 0);
        chk("rst_evt_time", 32'(evt_time_o), 0);
        chk("rst_late", 32'(evt_late_o), 0);
        chk("rst_late_cnt", 32'(late_cnt_o), 0);
        rand_in = 1'b0;
        flush_i = 1'b0;
        evt_ready_i = 1'b1;
        tick_en_i = 1'b1;
        drive_head();
        rst_ni = 1'b1;
        tb_time = '0;
        chk("count0", 32'(time_o), 0);
        step();
        chk("count1", 32'(time_o), 1);
        step();
        chk("count2", 32'(time_o), 2);

        // On-time release
        p0 = pop_cnt;
        push(TW'(5), TW'('hA));
        expect_evt(TW'('hA), TW'(5), 1'b0);
        wait_pop("ontime_pop", 20);
        chk("ontime_pop_time", 32'(time_o), 6);
        step();
        chk("ontime_single_pulse", 32'(q_pop_o), 0);
        repeat (4) step();
        chk("ontime_pops", 32'(pop_cnt - p0), 1);
        chk("ontime_late_cnt", 32'(late_cnt_o), 0);
        chk("ontime_sb_empty", 32'(exq.size()), 0);

        // Backpressure on an already expired head
        evt_ready_i = 1'b0;
        p0 = pop_cnt;
        push(TW'(0), TW'('h55));
        expect_evt(TW'('h55), TW'(0), 1'b1);
        wait_pop("bp_pop", 20);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp_valid_%0d", i), 32'(evt_valid_o), 1);
            chk($sformatf("bp_id_%0d", i), 32'(evt_id_o), 'h55);
        end
        chk("bp_pops", 32'(pop_cnt - p0), 1);
        evt_ready_i = 1'b1;
        step();
        chk("bp_valid_drop", 32'(evt_valid_o), 0);
        chk("bp_sb_empty", 32'(exq.size()), 0);

        // Table of compare cases at a frozen time base
        tick_en_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            d = tb_time + TW'(vt[i].delta);
            flush_i = vt[i].flush;
            p0 = pop_cnt;
            if (!vt[i].empty) begin
                push(d, TW'(256 + i));
                if (vt[i].exp_pop) expect_evt(TW'(256 + i), d, vt[i].exp_late);
            end
            drive_head();
            repeat (6) step();
            chk($sformatf("vec%0d_pops", i), 32'(pop_cnt - p0), 32'(vt[i].exp_pop));
            flush_i = 1'b0;
            mq.delete();
            drive_head();
            repeat (2) step();
        end
        chk("vec_sb_empty", 32'(exq.size()), 0);

        // Wrap-around of the time base
        do_reset();
        tick_en_i = 1'b1;
        while (tb_time != TW'('h1FFE)) step();
        chk("wrap_time_pre", 32'(time_o), 'h1FFE);
        push(TW'(1), TW'('h77));
        expect_evt(TW'('h77), TW'(1), 1'b0);
        wait_pop("wrap_pop", 20);
        chk("wrap_pop_time", 32'(time_o), 2);
        tick_en_i = 1'b0;
        push(TW'('h1FFD), TW'('h78));
        expect_evt(TW'('h78), TW'('h1FFD), 1'b1);
        wait_pop("wrap_late_pop", 6);
        chk("wrap_late_pop_time", 32'(time_o), 2);
        repeat (3) step();
        chk("wrap_late_cnt", 32'(late_cnt_o), 1);
        chk("wrap_sb_empty", 32'(exq.size()), 0);

        // Flush of three future entries
        do_reset();
        tick_en_i = 1'b0;
        push(TW'(3000), TW'(3));
        push(TW'(1000), TW'(1));
        push(TW'(2000), TW'(2));
        expect_evt(TW'(1), TW'(1000), 1'b0);
        expect_evt(TW'(2), TW'(2000), 1'b0);
        expect_evt(TW'(3), TW'(3000), 1'b0);
        flush_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p = pop_cnt;
            step();
            if (pop_cnt != p) pc.push_back(cyc);
        end
        chk("flush_pops", 32'(pc.size()), 3);
        if (pc.size() == 3) begin
            chk("flush_gap1", 32'(pc[1] - pc[0]), 3);
            chk("flush_gap2", 32'(pc[2] - pc[1]), 3);
        end
        chk("flush_sb_empty", 32'(exq.size()), 0);

        // Empty queue with flush held
        p0 = pop_cnt;
        repeat (50) step();
        chk("empty_no_pop", 32'(pop_cnt - p0), 0);
        flush_i = 1'b0;

        // Late counter saturation
        do_reset();
        tick_en_i = 1'b1;
        repeat (5) step();
        tick_en_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(TW'(k), TW'(512 + k));
            expect_evt(TW'(512 + k), TW'(k), 1'b1);
        end
        repeat (25) step();
        chk("sat_late_cnt", 32'(late_cnt_o), 3);
        chk("sat_sb_empty", 32'(exq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
